// File: rtl/net_csum_check.sv
`default_nettype none
// ============================================================================
// Module      : net_csum_check
// Description : Receive-side additive checksum verifier and trailer stripper.
//               Payload beats pass through a one-beat holding register so that
//               tlast can be moved from the trailer onto the final payload
//               beat. One status report is issued per completed packet.
// Config      : NET_CSUM_CNT_EN - when defined, adds the packet and error
//               counters; otherwise pkt_cnt_o and err_cnt_o read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module net_csum_check #(
  parameter int DATA_BITS = 512,  // must be a multiple of 32
  parameter int TID_BITS  = 6
) (
  input  logic                   aclk,
  input  logic                   areset,
  // input packet stream, trailer included
  input  logic [DATA_BITS-1:0]   s_axis_tdata_i,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep_i,
  input  logic [TID_BITS-1:0]    s_axis_tid_i,
  input  logic                   s_axis_tlast_i,
  input  logic                   s_axis_tvalid_i,
  output logic                   s_axis_tready_o,
  // output payload stream, trailer removed
  output logic [DATA_BITS-1:0]   m_axis_tdata_o,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep_o,
  output logic [TID_BITS-1:0]    m_axis_tid_o,
  output logic                   m_axis_tlast_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  // per-packet status
  output logic                   chk_valid_o,
  output logic                   chk_ok_o,
  output logic                   chk_runt_o,
  output logic [TID_BITS-1:0]    chk_tid_o,
  output logic [31:0]            pkt_cnt_o,
  output logic [31:0]            err_cnt_o
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int WORDS     = DATA_BITS / 32;

  // SOP: holding register empty; BODY: holding register holds a payload beat
  typedef enum logic [0:0] {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
  logic [KEEP_BITS-1:0]  hold_keep_q, hold_keep_d;
  logic [TID_BITS-1:0]   tid_q, tid_d;
  logic [31:0]           sum_q, sum_d;
  logic                  chk_valid_q, chk_valid_d;
  logic                  chk_ok_q, chk_ok_d;
  logic                  chk_runt_q, chk_runt_d;
  logic [TID_BITS-1:0]   chk_tid_q, chk_tid_d;

  logic [DATA_BITS-1:0]  masked;
  logic [31:0]           beat_sum;
  logic                  accept;

  // Bytes with tkeep low contribute zero to the checksum
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_BITS; gi++) begin : g_mask
      assign masked[gi*8 +: 8] = s_axis_tkeep_i[gi] ? s_axis_tdata_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Modulo-2^32 sum of every 32-bit word of the masked input beat
  always_comb begin
    beat_sum = 32'h0;
    for (int w = 0; w < WORDS; w++) begin
      beat_sum = beat_sum + masked[w*32 +: 32];
    end
  end

  // The input only stalls when a held beat is waiting on the sink; the held
  // beat is offered only alongside its successor, which supplies tlast.
  assign s_axis_tready_o = (state_q == ST_SOP) | m_axis_tready_i;
  assign accept          = s_axis_tvalid_i & s_axis_tready_o;

  assign m_axis_tvalid_o = (state_q == ST_BODY) & s_axis_tvalid_i;
  assign m_axis_tlast_o  = (state_q == ST_BODY) & s_axis_tlast_i;
  assign m_axis_tdata_o  = hold_data_q;
  assign m_axis_tkeep_o  = hold_keep_q;
  assign m_axis_tid_o    = tid_q;

  assign chk_valid_o = chk_valid_q;
  assign chk_ok_o    = chk_ok_q;
  assign chk_runt_o  = chk_runt_q;
  assign chk_tid_o   = chk_tid_q;

  // Next-state: packet parsing, hold register, running sum and status
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    tid_d       = tid_q;
    sum_d       = sum_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
    chk_runt_d  = chk_runt_q;
    chk_tid_d   = chk_tid_q;

    if (accept) begin
      case (state_q)
        ST_SOP: begin
          if (!s_axis_tlast_i) begin
            state_d     = ST_BODY;
            hold_data_d = s_axis_tdata_i;
            hold_keep_d = s_axis_tkeep_i;
            tid_d       = s_axis_tid_i;
            sum_d       = beat_sum;
          end else begin
            // trailer with no payload: nothing to forward, always a failure
            chk_valid_d = 1'b1;
            chk_ok_d    = 1'b0;
            chk_runt_d  = 1'b1;
            chk_tid_d   = s_axis_tid_i;
          end
        end
        ST_BODY: begin
          if (!s_axis_tlast_i) begin
            hold_data_d = s_axis_tdata_i;
            hold_keep_d = s_axis_tkeep_i;
            sum_d       = sum_q + beat_sum;
          end else begin
            state_d     = ST_SOP;
            hold_data_d = '0;
            hold_keep_d = '0;
            tid_d       = '0;
            sum_d       = 32'h0;
            chk_valid_d = 1'b1;
            chk_ok_d    = (sum_q == s_axis_tdata_i[31:0]);
            chk_runt_d  = 1'b0;
            chk_tid_d   = tid_q;
          end
        end
        default: state_d = ST_SOP;
      endcase
    end
  end

  // State, hold register and status registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_SOP;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      tid_q       <= '0;
      sum_q       <= 32'h0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      chk_runt_q  <= 1'b0;
      chk_tid_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      tid_q       <= tid_d;
      sum_q       <= sum_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      chk_runt_q  <= chk_runt_d;
      chk_tid_q   <= chk_tid_d;
    end
  end

`ifdef NET_CSUM_CNT_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  // Counters step on the same edge that raises chk_valid
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt_q <= 32'h0;
      err_cnt_q <= 32'h0;
    end else if (chk_valid_d) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (!chk_ok_d) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign pkt_cnt_o = 32'h0;
  assign err_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire
